// File: rtl/warp_regfile_pkg.sv
// Shared constants and types for the warp register file.
//   DEF_* : default lane/register/width/warp counts
//   clr_state_t : warp-clear sequencer states
package warp_regfile_pkg;

    localparam int unsigned DEF_NUM_LANES = 16;
    localparam int unsigned DEF_NUM_REGS  = 16;
    localparam int unsigned DEF_DATA_W    = 64;
    localparam int unsigned DEF_NUM_WARPS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

endpackage

// File: rtl/warp_register_file_if.sv
// Bus bundle for the warp register file: two read ports, one write port,
// and the warp-clear request/status.
//   master : requester side (drives enables/addresses/data, sees results)
//   slave  : register file side
interface warp_register_file_if #(
    parameter int unsigned NUM_LANES = warp_regfile_pkg::DEF_NUM_LANES,
    parameter int unsigned NUM_REGS  = warp_regfile_pkg::DEF_NUM_REGS,
    parameter int unsigned DATA_W    = warp_regfile_pkg::DEF_DATA_W,
    parameter int unsigned NUM_WARPS = warp_regfile_pkg::DEF_NUM_WARPS
) ();
    localparam int unsigned RA_W  = $clog2(NUM_REGS);
    localparam int unsigned WID_W = $clog2(NUM_WARPS);

    logic [NUM_LANES-1:0]        read_en_0;
    logic [RA_W-1:0]             raddr_0;
    logic [WID_W-1:0]            rwarp_0;
    logic [NUM_LANES*DATA_W-1:0] rdata_0;
    logic                        rvalid_0;

    logic [NUM_LANES-1:0]        read_en_1;
    logic [RA_W-1:0]             raddr_1;
    logic [WID_W-1:0]            rwarp_1;
    logic [NUM_LANES*DATA_W-1:0] rdata_1;
    logic                        rvalid_1;

    logic [NUM_LANES-1:0]        write_en;
    logic [RA_W-1:0]             waddr;
    logic [WID_W-1:0]            wwarp;
    logic [NUM_LANES*DATA_W-1:0] wdata;

    logic                        clr_req;
    logic [WID_W-1:0]            clr_warp;
    logic                        clr_busy;
    logic                        clr_done;

    modport master (
        output read_en_0, raddr_0, rwarp_0,
        output read_en_1, raddr_1, rwarp_1,
        output write_en, waddr, wwarp, wdata,
        output clr_req, clr_warp,
        input  rdata_0, rvalid_0, rdata_1, rvalid_1,
        input  clr_busy, clr_done
    );

    modport slave (
        input  read_en_0, raddr_0, rwarp_0,
        input  read_en_1, raddr_1, rwarp_1,
        input  write_en, waddr, wwarp, wdata,
        input  clr_req, clr_warp,
        output rdata_0, rvalid_0, rdata_1, rvalid_1,
        output clr_busy, clr_done
    );

endinterface

// File: rtl/warp_regfile_lane.sv
// One lane's storage for every warp and register.
//   we/waddr/wwarp/wdata       : external write (already gated by the top)
//   clr_en/clr_addr/clr_warp   : zeroing write from the clear sequencer
//   re_p/raddr_p/rwarp_p       : read port p request (gated by the top)
//   rdata_p                    : registered read data, zero when re_p is low,
//                                bypasses a same-cycle write to the same entry
module warp_regfile_lane #(
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned NUM_WARPS = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         we,
    input  logic [$clog2(NUM_REGS)-1:0]  waddr,
    input  logic [$clog2(NUM_WARPS)-1:0] wwarp,
    input  logic [DATA_W-1:0]            wdata,
    input  logic                         clr_en,
    input  logic [$clog2(NUM_REGS)-1:0]  clr_addr,
    input  logic [$clog2(NUM_WARPS)-1:0] clr_warp,
    input  logic                         re_0,
    input  logic [$clog2(NUM_REGS)-1:0]  raddr_0,
    input  logic [$clog2(NUM_WARPS)-1:0] rwarp_0,
    output logic [DATA_W-1:0]            rdata_0,
    input  logic                         re_1,
    input  logic [$clog2(NUM_REGS)-1:0]  raddr_1,
    input  logic [$clog2(NUM_WARPS)-1:0] rwarp_1,
    output logic [DATA_W-1:0]            rdata_1
);

    logic [DATA_W-1:0] mem [NUM_WARPS][NUM_REGS];

    logic hit_0_c;
    logic hit_1_c;

    assign hit_0_c = we && (waddr == raddr_0) && (wwarp == rwarp_0);
    assign hit_1_c = we && (waddr == raddr_1) && (wwarp == rwarp_1);

    // Storage is deliberately not reset; zeroing goes through the clear path.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wwarp][waddr] <= wdata;
        end
        if (clr_en) begin
            mem[clr_warp][clr_addr] <= '0;
        end
    end

    // Read port 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_0 <= '0;
        end else if (!re_0) begin
            rdata_0 <= '0;
        end else if (hit_0_c) begin
            rdata_0 <= wdata;
        end else begin
            rdata_0 <= mem[rwarp_0][raddr_0];
        end
    end

    // Read port 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_1 <= '0;
        end else if (!re_1) begin
            rdata_1 <= '0;
        end else if (hit_1_c) begin
            rdata_1 <= wdata;
        end else begin
            rdata_1 <= mem[rwarp_1][raddr_1];
        end
    end

endmodule

// File: rtl/warp_register_file.sv
// Multi-warp, multi-lane register file with two independent read ports,
// one lane-masked write port and a sequenced per-warp clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : warp_register_file_if slave (read ports 0/1, write port,
//                clr_req/clr_warp in, clr_busy/clr_done out)
module warp_register_file
    import warp_regfile_pkg::*;
#(
    parameter int unsigned NUM_LANES = DEF_NUM_LANES,
    parameter int unsigned NUM_REGS  = DEF_NUM_REGS,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned NUM_WARPS = DEF_NUM_WARPS
) (
    input  logic               clk,
    input  logic               rst_n,
    warp_register_file_if.slave bus
);

    localparam int unsigned RA_W  = $clog2(NUM_REGS);
    localparam int unsigned WID_W = $clog2(NUM_WARPS);
    localparam logic [RA_W-1:0] LAST_REG = RA_W'(NUM_REGS - 1);

    clr_state_t        state;
    logic [RA_W-1:0]   cnt;
    logic [WID_W-1:0]  clr_warp_q;
    logic              clr_busy_q;
    logic              clr_done_q;
    logic              rvalid_0_q;
    logic              rvalid_1_q;

    logic                 busy_c;
    logic                 accept_c;
    logic                 wr_drop_c;
    logic                 kill_0_c;
    logic                 kill_1_c;
    logic [NUM_LANES-1:0] we_c;
    logic [NUM_LANES-1:0] re_0_c;
    logic [NUM_LANES-1:0] re_1_c;
    logic                 clr_wr_c;

    assign busy_c   = (state != IDLE);
    assign accept_c = (state == IDLE) && bus.clr_req;
    assign clr_wr_c = (state == CLEAR);

    // Writes to the warp under clear are dropped, including the accept cycle.
    assign wr_drop_c = (busy_c && (bus.wwarp == clr_warp_q)) ||
                       (accept_c && (bus.wwarp == bus.clr_warp));
    assign we_c      = wr_drop_c ? '0 : bus.write_en;

    // Reads of the warp under clear return zero; rvalid uses the raw enables.
    assign kill_0_c = busy_c && (bus.rwarp_0 == clr_warp_q);
    assign kill_1_c = busy_c && (bus.rwarp_1 == clr_warp_q);
    assign re_0_c   = kill_0_c ? '0 : bus.read_en_0;
    assign re_1_c   = kill_1_c ? '0 : bus.read_en_1;

    // Clear sequencer: one register of the latched warp zeroed per CLEAR cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            clr_warp_q <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clr_req) begin
                        state      <= CLEAR;
                        clr_warp_q <= bus.clr_warp;
                        cnt        <= '0;
                        clr_busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt == LAST_REG) begin
                        state      <= DONE;
                        cnt        <= '0;
                        clr_done_q <= 1'b1;
                    end else begin
                        cnt <= cnt + RA_W'(1);
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    clr_busy_q <= 1'b0;
                    clr_done_q <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    clr_busy_q <= 1'b0;
                    clr_done_q <= 1'b0;
                end
            endcase
        end
    end

    // Read-valid flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_0_q <= 1'b0;
            rvalid_1_q <= 1'b0;
        end else begin
            rvalid_0_q <= |bus.read_en_0;
            rvalid_1_q <= |bus.read_en_1;
        end
    end

    assign bus.clr_busy = clr_busy_q;
    assign bus.clr_done = clr_done_q;
    assign bus.rvalid_0 = rvalid_0_q;
    assign bus.rvalid_1 = rvalid_1_q;

    // Lane array
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [DATA_W-1:0] rd_0;
        logic [DATA_W-1:0] rd_1;

        warp_regfile_lane #(
            .NUM_REGS  (NUM_REGS),
            .DATA_W    (DATA_W),
            .NUM_WARPS (NUM_WARPS)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .we       (we_c[i]),
            .waddr    (bus.waddr),
            .wwarp    (bus.wwarp),
            .wdata    (bus.wdata[i*DATA_W +: DATA_W]),
            .clr_en   (clr_wr_c),
            .clr_addr (cnt),
            .clr_warp (clr_warp_q),
            .re_0     (re_0_c[i]),
            .raddr_0  (bus.raddr_0),
            .rwarp_0  (bus.rwarp_0),
            .rdata_0  (rd_0),
            .re_1     (re_1_c[i]),
            .raddr_1  (bus.raddr_1),
            .rwarp_1  (bus.rwarp_1),
            .rdata_1  (rd_1)
        );

        assign bus.rdata_0[i*DATA_W +: DATA_W] = rd_0;
        assign bus.rdata_1[i*DATA_W +: DATA_W] = rd_1;
    end

endmodule

// File: tb/tb_warp_register_file.sv
// Directed self-checking bench for warp_register_file (default parameters).
module tb_warp_register_file;

    localparam int unsigned NL = 16;
    localparam int unsigned DW = 64;

    logic clk;
    logic rst_n;

    int total;
    int bad;

    warp_register_file_if bus ();

    warp_register_file dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pat(input int w, input int r, input int i);
        return {16'hC0DE, 16'(w), 16'(r), 16'(i)};
    endfunction

    function automatic logic [63:0] lane0(input int i);
        logic [NL*DW-1:0] v;
        v = bus.rdata_0;
        return v[i*DW +: DW];
    endfunction

    function automatic logic [63:0] lane1(input int i);
        logic [NL*DW-1:0] v;
        v = bus.rdata_1;
        return v[i*DW +: DW];
    endfunction

    task automatic idle_inputs();
        bus.read_en_0 = '0; bus.raddr_0 = '0; bus.rwarp_0 = '0;
        bus.read_en_1 = '0; bus.raddr_1 = '0; bus.rwarp_1 = '0;
        bus.write_en  = '0; bus.waddr   = '0; bus.wwarp   = '0;
        bus.wdata     = '0;
        bus.clr_req   = 1'b0; bus.clr_warp = '0;
    endtask

    task automatic set_write_base(input int w, input int r, input logic [15:0] en,
                                  input logic [63:0] base);
        bus.write_en = en;
        bus.wwarp    = 3'(w);
        bus.waddr    = 4'(r);
        for (int i = 0; i < NL; i++) bus.wdata[i*DW +: DW] = base + 64'(i);
    endtask

    task automatic fill_warp(input int w);
        for (int r = 0; r < 16; r++) begin
            bus.write_en = '1;
            bus.wwarp    = 3'(w);
            bus.waddr    = 4'(r);
            for (int i = 0; i < NL; i++) bus.wdata[i*DW +: DW] = pat(w, r, i);
            tick();
        end
        bus.write_en = '0;
    endtask

    initial begin
        int busy_n;
        int done_n;
        logic done_seen;

        total = 0;
        bad   = 0;
        idle_inputs();
        rst_n = 1'b0;

        // Reset state
        tick();
        check_eq("rst_rvalid_0", 64'(bus.rvalid_0), 64'd0);
        check_eq("rst_rvalid_1", 64'(bus.rvalid_1), 64'd0);
        check_eq("rst_clr_busy", 64'(bus.clr_busy), 64'd0);
        check_eq("rst_clr_done", 64'(bus.clr_done), 64'd0);
        check_eq("rst_rdata_0", lane0(0), 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic write then read, warp 0 reg 3
        set_write_base(0, 3, 16'hFFFF, 64'hA5A5_0000_0000_0000);
        tick();
        bus.write_en  = '0;
        bus.read_en_0 = '1; bus.raddr_0 = 4'd3; bus.rwarp_0 = 3'd0;
        tick();
        check_eq("basic_rvalid_0", 64'(bus.rvalid_0), 64'd1);
        for (int i = 0; i < NL; i++)
            check_eq($sformatf("basic_lane%0d", i), lane0(i), 64'hA5A5_0000_0000_0000 + 64'(i));
        bus.read_en_0 = '0;
        tick();
        check_eq("idle_rvalid_0", 64'(bus.rvalid_0), 64'd0);
        check_eq("idle_rdata_0", lane0(0), 64'd0);

        // Same-cycle write/read bypass on port 1
        bus.write_en = 16'h0080; bus.wwarp = 3'd2; bus.waddr = 4'd5;
        bus.wdata    = '0;
        bus.wdata[7*DW +: DW] = 64'hDEAD_BEEF;
        bus.read_en_1 = 16'h0080; bus.rwarp_1 = 3'd2; bus.raddr_1 = 4'd5;
        tick();
        check_eq("byp_rvalid_1", 64'(bus.rvalid_1), 64'd1);
        check_eq("byp_lane7", lane1(7), 64'hDEAD_BEEF);
        check_eq("byp_lane6_off", lane1(6), 64'd0);
        bus.write_en = '0; bus.read_en_1 = '0;

        // Lane-masked write and masked read, plus port 1 on another warp
        set_write_base(0, 3, 16'h00FF, 64'h1111_0000_0000_0000);
        tick();
        bus.write_en  = '0;
        bus.read_en_0 = 16'h0F0F; bus.raddr_0 = 4'd3; bus.rwarp_0 = 3'd0;
        bus.read_en_1 = 16'h0080; bus.raddr_1 = 4'd5; bus.rwarp_1 = 3'd2;
        tick();
        for (int i = 0; i < NL; i++) begin
            logic [63:0] e;
            if (i < 4)                e = 64'h1111_0000_0000_0000 + 64'(i);
            else if (i >= 8 && i < 12) e = 64'hA5A5_0000_0000_0000 + 64'(i);
            else                      e = 64'd0;
            check_eq($sformatf("mask_lane%0d", i), lane0(i), e);
        end
        check_eq("indep_p1_lane7", lane1(7), 64'hDEAD_BEEF);
        bus.read_en_0 = '0; bus.read_en_1 = '0;

        // Clear of warp 5 with neighbours 4 and 6 populated
        fill_warp(4);
        fill_warp(5);
        fill_warp(6);
        bus.clr_req = 1'b1; bus.clr_warp = 3'd5;
        tick();
        bus.clr_req = 1'b0;
        busy_n = 0;
        done_n = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.clr_busy) busy_n++;
            if (bus.clr_done) done_n++;
            if (!bus.clr_busy) break;
            tick();
        end
        check_eq("clr5_busy_cycles", 64'(busy_n), 64'd17);
        check_eq("clr5_done_pulses", 64'(done_n), 64'd1);
        for (int r = 0; r < 16; r++) begin
            bus.read_en_0 = '1; bus.raddr_0 = 4'(r); bus.rwarp_0 = 3'd5;
            bus.read_en_1 = '1; bus.raddr_1 = 4'(r); bus.rwarp_1 = 3'd4;
            tick();
            for (int i = 0; i < NL; i++) begin
                check_eq($sformatf("clr5_w5_r%0d_l%0d", r, i), lane0(i), 64'd0);
                check_eq($sformatf("clr5_w4_r%0d_l%0d", r, i), lane1(i), pat(4, r, i));
            end
        end
        for (int r = 0; r < 16; r++) begin
            bus.read_en_1 = '1; bus.raddr_1 = 4'(r); bus.rwarp_1 = 3'd6;
            tick();
            for (int i = 0; i < NL; i++)
                check_eq($sformatf("clr5_w6_r%0d_l%0d", r, i), lane1(i), pat(6, r, i));
        end
        bus.read_en_0 = '0; bus.read_en_1 = '0;

        // Activity during a clear of warp 1
        bus.clr_req = 1'b1; bus.clr_warp = 3'd1;
        tick();
        bus.clr_req = 1'b0;
        tick();
        tick();
        set_write_base(1, 0, 16'hFFFF, 64'h7777_0000_0000_0000);
        bus.clr_req = 1'b1; bus.clr_warp = 3'd3;
        bus.read_en_0 = '1; bus.raddr_0 = 4'd0; bus.rwarp_0 = 3'd1;
        tick();
        check_eq("clr1_read_rvalid", 64'(bus.rvalid_0), 64'd1);
        check_eq("clr1_read_lane0", lane0(0), 64'd0);
        check_eq("clr1_read_lane15", lane0(15), 64'd0);
        bus.clr_req = 1'b0; bus.read_en_0 = '0;
        set_write_base(2, 1, 16'hFFFF, 64'h5555_0000_0000_0000);
        tick();
        bus.write_en = '0;
        done_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.clr_done) begin
                done_seen = 1'b1;
                break;
            end
            tick();
        end
        check_eq("clr1_done_seen", 64'(done_seen), 64'd1);
        tick();
        tick();
        check_eq("clr1_no_restart", 64'(bus.clr_busy), 64'd0);
        bus.read_en_0 = '1; bus.raddr_0 = 4'd0; bus.rwarp_0 = 3'd1;
        bus.read_en_1 = '1; bus.raddr_1 = 4'd1; bus.rwarp_1 = 3'd2;
        tick();
        for (int i = 0; i < NL; i++) begin
            check_eq($sformatf("clr1_w1_drop_l%0d", i), lane0(i), 64'd0);
            check_eq($sformatf("clr1_w2_kept_l%0d", i), lane1(i), 64'h5555_0000_0000_0000 + 64'(i));
        end
        bus.read_en_0 = '0; bus.read_en_1 = '0;

        // Reset during clear of warp 7, with a write in the accept cycle
        fill_warp(7);
        bus.clr_req = 1'b1; bus.clr_warp = 3'd7;
        set_write_base(7, 15, 16'hFFFF, 64'hBAD0_0000_0000_0000);
        tick();
        bus.clr_req = 1'b0; bus.write_en = '0;
        tick();
        tick();
        tick();
        bus.read_en_0 = '1; bus.raddr_0 = 4'd0; bus.rwarp_0 = 3'd4;
        tick();
        check_eq("abort_pre_busy", 64'(bus.clr_busy), 64'd1);
        check_eq("abort_pre_rdata", lane0(0), pat(4, 0, 0));
        rst_n = 1'b0;
        bus.read_en_0 = '0;
        #1;
        check_eq("abort_rdata_0", lane0(0), 64'd0);
        check_eq("abort_rvalid_0", 64'(bus.rvalid_0), 64'd0);
        check_eq("abort_busy", 64'(bus.clr_busy), 64'd0);
        check_eq("abort_done", 64'(bus.clr_done), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        done_n = 0;
        busy_n = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.clr_done) done_n++;
            if (bus.clr_busy) busy_n++;
        end
        check_eq("abort_no_done", 64'(done_n), 64'd0);
        check_eq("abort_idle", 64'(busy_n), 64'd0);
        for (int r = 0; r < 16; r++) begin
            bus.read_en_0 = '1; bus.raddr_0 = 4'(r); bus.rwarp_0 = 3'd7;
            tick();
            for (int i = 0; i < NL; i++)
                check_eq($sformatf("abort_w7_r%0d_l%0d", r, i), lane0(i),
                         (r < 4) ? 64'd0 : pat(7, r, i));
        end
        bus.read_en_0 = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
